// File: rtl/sha256_pkg.sv
// SHA-256 constants, round functions and loader state encoding shared by
// the midstate loader and its message schedule window.
package sha256_pkg;

    localparam int HDR_WORDS = 20;
    localparam int ROUNDS    = 64;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return ror32(x, 2) ^ ror32(x, 13) ^ ror32(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return ror32(x, 6) ^ ror32(x, 11) ^ ror32(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return ror32(x, 7) ^ ror32(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/msg_sched16.sv
// Sliding 16-word SHA-256 message schedule: win[0] is always the current
// round's word, and each shift appends the next expanded word at the top.
module msg_sched16
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic [3:0]  load_idx,
    input  logic [31:0] load_word,
    input  logic        shift_en,
    output logic [31:0] wr
);

    logic [31:0] win [0:15];
    logic [31:0] w_next;

    assign wr = win[0];
    // With the window holding W[r..r+15], this yields W[r+16].
    assign w_next = win[0] + small_sigma0(win[1]) + win[9] + small_sigma1(win[14]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else if (load_en) begin
            win[load_idx] <= load_word;
        end else if (shift_en) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i + 1];
            win[15] <= w_next;
        end
    end

endmodule

// File: rtl/midstate_loader.sv
// Header loader and iterative SHA-256 block-0 compressor producing the miner
// work pair (midstate + tail words). Build option HDR_BSWAP_EN byte-reverses input words.
module midstate_loader
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  hdr_word,
    input  logic         hdr_valid,
    output logic         hdr_ready,
    input  logic         work_abort,
    output logic [255:0] mid,
    output logic [127:0] data,
    output logic         work_valid,
    input  logic         work_ready,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    // Handshakes: a transfer happens on the rising edge where valid && ready
    // are both high; valid holders keep payload stable until that edge, and
    // work_abort overrides any transfer in the same cycle.

    state_t      state;
    logic [4:0]  word_cnt;
    logic [5:0]  round_cnt;
    logic [31:0] st [0:7];
    logic [31:0] nx [0:7];
    logic [31:0] hdr_w;
    logic [31:0] wr;
    logic [31:0] t1;
    logic [31:0] t2;
    logic        hdr_acc;
    logic        work_acc;

`ifdef HDR_BSWAP_EN
    assign hdr_w = bswap32(hdr_word);
`else
    assign hdr_w = hdr_word;
`endif

    assign hdr_acc   = hdr_valid && hdr_ready && (state == LOAD);
    assign work_acc  = work_valid && work_ready && (state == DONE);
    assign dbg_state = state;

    msg_sched16 u_sched (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (hdr_acc && !work_abort && (word_cnt < 5'd16)),
        .load_idx  (word_cnt[3:0]),
        .load_word (hdr_w),
        .shift_en  ((state == ROUND) && !work_abort),
        .wr        (wr)
    );

    always_comb begin
        t1 = st[7] + big_sigma1(st[4]) + ch(st[4], st[5], st[6]) + K[round_cnt] + wr;
        t2 = big_sigma0(st[0]) + maj(st[0], st[1], st[2]);
        nx[0] = t1 + t2;
        nx[1] = st[0];
        nx[2] = st[1];
        nx[3] = st[2];
        nx[4] = st[3] + t1;
        nx[5] = st[4];
        nx[6] = st[5];
        nx[7] = st[6];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            word_cnt   <= '0;
            round_cnt  <= '0;
            mid        <= '0;
            data       <= '0;
            work_valid <= 1'b0;
            busy       <= 1'b0;
            hdr_ready  <= 1'b0;
            for (int i = 0; i < 8; i++) st[i] <= '0;
        end else if (work_abort) begin
            // mid/data intentionally keep their last values.
            state      <= LOAD;
            word_cnt   <= '0;
            round_cnt  <= '0;
            work_valid <= 1'b0;
            busy       <= 1'b0;
            hdr_ready  <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    for (int i = 0; i < 8; i++) st[i] <= IV[i];
                    hdr_ready <= 1'b1;
                    if (hdr_acc) begin
                        if (word_cnt >= 5'd16) data[{word_cnt[1:0], 5'd0} +: 32] <= hdr_w;
                        if (word_cnt == 5'(HDR_WORDS - 1)) begin
                            word_cnt  <= '0;
                            round_cnt <= '0;
                            state     <= ROUND;
                            hdr_ready <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + 5'd1;
                        end
                    end
                end
                ROUND: begin
                    for (int i = 0; i < 8; i++) st[i] <= nx[i];
                    round_cnt <= round_cnt + 6'd1;
                    if (round_cnt == 6'(ROUNDS - 1)) begin
                        for (int i = 0; i < 8; i++) mid[32*i +: 32] <= nx[i] + IV[i];
                        state      <= DONE;
                        busy       <= 1'b0;
                        work_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (work_acc) begin
                        work_valid <= 1'b0;
                        hdr_ready  <= 1'b1;
                        state      <= LOAD;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule
